// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR sequence controller.
//   LFSR_W   - LFSR register width
//   TAP_MASK - feedback taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   cmd_op_e - command opcodes carried on cmd_op
//   fsm_e    - controller FSM states
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;

  // Tap positions 15, 13, 12, 10 of the shift register
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'b1011_0100_0000_0000;

  localparam logic [LFSR_W-1:0] LFSR_RESET_VAL = 16'h0001;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_STEP = 2'b01,
    OP_MEAS = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEAS,
    RESP
  } fsm_e;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// lfsr_seq_ctrl_if: command / response bus of the LFSR sequence controller.
//   cmd_valid/cmd_ready/cmd_op/cmd_data - command handshake
//   abort                               - cancel a running STEP/MEASURE
//   state                               - live LFSR register value
//   rsp_valid/rsp_ready/rsp_data/rsp_err - response handshake
// master = command issuer / response consumer, slave = controller.
interface lfsr_seq_ctrl_if
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 17
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LFSR_W-1:0] cmd_data;
  logic              abort;
  logic [LFSR_W-1:0] state;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [CNT_W-1:0]  rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, abort, rsp_ready,
    input  cmd_ready, state, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, abort, rsp_ready,
    output cmd_ready, state, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/lfsr_next.sv
// lfsr_next: combinational Fibonacci LFSR next-state function.
//   cur - current register value
//   nxt - value after one shift: {cur[14:0], parity of tapped bits}
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);
  assign nxt = {cur[LFSR_W-2:0], ^(cur & TAP_MASK)};
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command-driven 16-bit LFSR controller.
//   clk   - single clock, rising edge
//   reset - synchronous, active-low
//   bus   - slave side of lfsr_seq_ctrl_if (commands, abort, live state,
//           response with step count / measured period and error flag)
// Commands: LOAD seed, STEP n, MEASURE period (bounded by TIMEOUT).
// Each accepted command yields exactly one response unless reset intervenes.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int TIMEOUT = 65536,
  parameter int CNT_W   = 17
) (
  input  logic            clk,
  input  logic            reset,
  lfsr_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  fsm_e              fsm;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [LFSR_W-1:0] start;
  logic [LFSR_W-1:0] left;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              rsp_valid_q;
  logic [CNT_W-1:0]  rsp_data_q;
  logic              rsp_err_q;

  lfsr_next u_next (
    .cur (lfsr),
    .nxt (lfsr_nxt)
  );

  assign cnt_inc       = cnt + CNT_W'(1);
  assign bus.cmd_ready = reset && (fsm == IDLE);
  assign bus.state     = lfsr;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

  // cnt counts advances done (reported on abort / completion);
  // left counts advances still owed by a STEP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm         <= IDLE;
      lfsr        <= LFSR_RESET_VAL;
      start       <= '0;
      left        <= '0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (bus.cmd_valid) begin
            cnt <= '0;
            unique case (cmd_op_e'(bus.cmd_op))
              OP_LOAD: begin
                lfsr        <= bus.cmd_data;
                fsm         <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= (bus.cmd_data == '0);
              end
              OP_STEP: begin
                if (bus.cmd_data == '0) begin
                  fsm         <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b0;
                end else begin
                  left <= bus.cmd_data;
                  fsm  <= RUN;
                end
              end
              OP_MEAS: begin
                start <= lfsr;
                if (lfsr == '0) begin
                  fsm         <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                end else begin
                  fsm <= MEAS;
                end
              end
              default: begin
                fsm         <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end

        RUN: begin
          // abort takes priority over the step, including the final one
          if (bus.abort) begin
            fsm         <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cnt;
            rsp_err_q   <= 1'b1;
          end else begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt_inc;
            left <= left - 16'd1;
            if (left == 16'd1) begin
              fsm         <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= cnt_inc;
              rsp_err_q   <= 1'b0;
            end
          end
        end

        MEAS: begin
          if (bus.abort) begin
            fsm         <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cnt;
            rsp_err_q   <= 1'b1;
          end else begin
            lfsr <= lfsr_nxt;
            cnt  <= cnt_inc;
            // a repeat on the same cycle as the timeout still counts as a period
            if (lfsr_nxt == start) begin
              fsm         <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= cnt_inc;
              rsp_err_q   <= 1'b0;
            end else if (cnt_inc == TO_CNT) begin
              fsm         <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= TO_CNT;
              rsp_err_q   <= 1'b1;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            fsm         <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
